alarm_ctrl_multi: RTL
=====================

Name: alarm_ctrl_multi

Overview:
Parametrised alarm controller for the BCD alarm-clock datapath. It supports NUM_ALARMS independent alarm slots, a configurable snooze interval and a snooze limit, an automatic ring timeout, and a registered display mux. It sits between the HH:MM BCD time counter and the 7-segment display/buzzer drivers. All state is synchronous to clk.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..8)
SNOOZE_MIN, 5, snooze interval in minutes (1..59)
MAX_SNOOZES, 3, snoozes allowed per ring event (1..15); further snooze requests are ignored
RING_TIMEOUT, 10, minutes of unattended ringing before auto-stop (1..59)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
one_minute  input  1  one-cycle pulse, once per minute, coincident with the new current_time
current_time  input  16  BCD HH:MM {ms_hour, ls_hour, ms_min, ls_min}
alarm_time  input  16*NUM_ALARMS  BCD alarm slots; slot i is at [16*i+15:16*i]
alarm_enable  input  NUM_ALARMS  per-slot enable
snooze  input  1  one-cycle pulse
stop_alarm  input  1  one-cycle pulse
show_alarm  input  1  1 = display the selected alarm slot
show_sel  input  3  slot index for display
display  output  16  registered BCD display value
sound_alarm  output  1  high while in RINGING
active_alarm  output  3  index of the slot that caused the current ring event
snooze_count  output  4  snoozes used in the current ring event

Behaviour:
- Reset: state=IDLE; sound_alarm=0, active_alarm=0, snooze_count=0, display=16'h0000; internal wake_time=0, ring_min=0.
- FSM states: IDLE, RINGING, SNOOZING. sound_alarm is registered and equals (state==RINGING).
- Per-cycle priority: reset > stop_alarm > snooze > one_minute.
- IDLE: on one_minute, if any slot i has alarm_enable[i]=1 and alarm_time slot i == current_time, go to RINGING next cycle. The lowest matching index wins and is latched into active_alarm. snooze_count=0, ring_min=0.
- RINGING:
  - stop_alarm: go to IDLE; clear snooze_count and ring_min.
  - snooze with snooze_count<MAX_SNOOZES: wake_time = current_time + SNOOZE_MIN (BCD, minutes carry into hours, 23:59 wraps to 00:xx); snooze_count+1; go to SNOOZING.
  - snooze with snooze_count==MAX_SNOOZES: ignored; stays RINGING.
  - one_minute: ring_min+1. When ring_min reaches RING_TIMEOUT, go to IDLE and clear snooze_count.
  - New alarm matches while RINGING are ignored; active_alarm is not changed.
- SNOOZING:
  - stop_alarm: go to IDLE; clear snooze_count.
  - snooze: ignored.
  - one_minute with current_time==wake_time: go to RINGING; ring_min=0.
  - Alarm-slot matches are ignored.
- Simultaneous snooze and one_minute in RINGING: snooze is taken; the tick does not advance ring_min.
- Simultaneous stop_alarm and any other input: go to IDLE.
- Reset mid-ring or mid-snooze: go to IDLE on the next edge with all outputs at their reset values.
- BCD add: input digits are assumed legal (hours 00-23, minutes 00-59). Adding SNOOZE_MIN must never produce an illegal digit. Examples: 23:58+5 → 00:03; 09:59+1 → 10:00.
- Display, one-cycle latency:
  - show_alarm=1 and show_sel<NUM_ALARMS: display = alarm_time slot show_sel.
  - show_alarm=1 and show_sel≥NUM_ALARMS: display = 16'h0000.
  - Otherwise: display = current_time.
- Unused upper bits of active_alarm are 0.

Test Plan:
- Reset, then alarm slot 2 = 16'h0730 enabled, slot 0 disabled; tick with current_time=16'h0730 → next cycle sound_alarm=1, active_alarm=2, snooze_count=0.
- Two enabled slots (1 and 3) both 16'h0600; tick at 06:00 → active_alarm=1. stop_alarm → sound_alarm=0 next cycle; snooze_count=0.
- Ringing at 23:58, snooze pulse → SNOOZING, snooze_count=1. Ticks through 23:59 ... 00:02 keep sound_alarm=0; tick at 16'h0003 → sound_alarm=1.
- MAX_SNOOZES=3: snooze three times, each followed by re-ring → fourth snooze is ignored; sound_alarm stays 1 and snooze_count=3.
- Ringing with no action: RING_TIMEOUT=10 ticks → sound_alarm=0 after the 10th tick, state IDLE, snooze_count=0. Snooze and tick in the same cycle → snooze wins and ring_min does not advance.
- Display: show_alarm=1, show_sel=3, slot 3 = 16'h1245 → display=16'h1245 one cycle later. show_sel=5 with NUM_ALARMS=4 → 16'h0000. show_alarm=0 → current_time. Reset asserted mid-SNOOZING → all outputs at reset values next cycle.

Source files
------------

// File: rtl/alarm_ctrl_multi.sv
// alarm_ctrl_multi
// ----------------
// Alarm controller for the BCD HH:MM alarm-clock datapath. It sits between
// the time counter and the 7-segment display and buzzer drivers.
//
// It does four things:
//   - compares the current time against NUM_ALARMS enabled alarm slots
//   - rings until the alarm is stopped, snoozed or times out
//   - snoozes for SNOOZE_MIN minutes, up to MAX_SNOOZES times per ring event
//   - drives a registered display mux that shows the time or one alarm slot
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   one_minute    one-cycle tick, coincident with the new current_time
//   current_time  BCD {ms_hour, ls_hour, ms_min, ls_min}
//   alarm_time    NUM_ALARMS packed BCD slots; slot i is at [16*i+15:16*i]
//   alarm_enable  per-slot enable
//   snooze        one-cycle snooze request
//   stop_alarm    one-cycle stop request
//   show_alarm    1 = show the slot chosen by show_sel on the display
//   show_sel      slot index for the display
//   display       registered BCD display value
//   sound_alarm   high while ringing
//   active_alarm  slot that caused the current ring event
//   snooze_count  snoozes used in the current ring event

// Per-slot comparator. One instance is generated for each alarm slot.
module alarm_slot_match (
   input  logic [15:0] slot_time,
   input  logic        slot_en,
   input  logic [15:0] current_time,
   output logic        hit
);
   assign hit = slot_en && (slot_time == current_time);
endmodule

module alarm_ctrl_multi #(
   parameter int unsigned NUM_ALARMS   = 4,
   parameter int unsigned SNOOZE_MIN   = 5,
   parameter int unsigned MAX_SNOOZES  = 3,
   parameter int unsigned RING_TIMEOUT = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     one_minute,
   input  logic [15:0]              current_time,
   input  logic [16*NUM_ALARMS-1:0] alarm_time,
   input  logic [NUM_ALARMS-1:0]    alarm_enable,
   input  logic                     snooze,
   input  logic                     stop_alarm,
   input  logic                     show_alarm,
   input  logic [2:0]               show_sel,
   output logic [15:0]              display,
   output logic                     sound_alarm,
   output logic [2:0]               active_alarm,
   output logic [3:0]               snooze_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RINGING  = 2'd1,
      SNOOZING = 2'd2
   } state_t;

   // The whole ring-event context is kept in one register. This lets the
   // next-state logic start from "hold everything" and change only the
   // fields that move.
   typedef struct packed {
      state_t      state;
      logic [2:0]  active;
      logic [3:0]  snz_cnt;
      logic [5:0]  ring_min;
      logic [15:0] wake_time;
   } ctrl_t;

   ctrl_t q, d;

   logic [NUM_ALARMS-1:0][15:0] slots;
   logic [NUM_ALARMS-1:0]       hit;
   logic                        any_hit;
   logic [2:0]                  hit_idx;
   logic [15:0]                 disp_nxt;
   logic [15:0]                 wake_nxt;

   assign slots = alarm_time;

   // ---------------------------------------------------------------------
   // Slot comparators
   // ---------------------------------------------------------------------
   generate
      for (genvar i = 0; i < int'(NUM_ALARMS); i++) begin : g_slot
         alarm_slot_match u_match (
            .slot_time    (slots[i]),
            .slot_en      (alarm_enable[i]),
            .current_time (current_time),
            .hit          (hit[i])
         );
      end
   endgenerate

   // The loop scans from the highest slot down, so the lowest matching
   // slot is the one that is kept.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = 3'd0;
      for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // BCD time + SNOOZE_MIN
   // ---------------------------------------------------------------------
   // The digits are converted to binary, added, and converted back.
   // SNOOZE_MIN is at most 59, so one subtraction of 60 is enough to
   // normalise the minutes. Hour 24 wraps to 00.
   function automatic logic [15:0] add_snooze(input logic [15:0] t);
      int unsigned m;
      int unsigned h;
      m = 32'(t[7:4]) * 32'd10 + 32'(t[3:0]) + SNOOZE_MIN;
      h = 32'(t[15:12]) * 32'd10 + 32'(t[11:8]);
      if (m >= 32'd60) begin
         m = m - 32'd60;
         h = h + 32'd1;
      end
      if (h >= 32'd24) h = h - 32'd24;
      return {4'(h / 32'd10), 4'(h % 32'd10), 4'(m / 32'd10), 4'(m % 32'd10)};
   endfunction

   assign wake_nxt = add_snooze(current_time);

   // ---------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------
   always_comb begin
      d = q;
      if (stop_alarm) begin
         // Stop overrides every other input in every state.
         d.state    = IDLE;
         d.snz_cnt  = 4'd0;
         d.ring_min = 6'd0;
      end else begin
         case (q.state)
            IDLE: begin
               if (one_minute && any_hit) begin
                  d.state    = RINGING;
                  d.active   = hit_idx;
                  d.snz_cnt  = 4'd0;
                  d.ring_min = 6'd0;
               end
            end
            RINGING: begin
               if (snooze && (q.snz_cnt < 4'(MAX_SNOOZES))) begin
                  // A snooze that is taken also absorbs a tick arriving in
                  // the same cycle.
                  d.state     = SNOOZING;
                  d.wake_time = wake_nxt;
                  d.snz_cnt   = q.snz_cnt + 4'd1;
                  d.ring_min  = 6'd0;
               end else if (one_minute) begin
                  // An exhausted snooze request is simply ignored, so it
                  // does not block the ring-timeout tick.
                  if ((q.ring_min + 6'd1) == 6'(RING_TIMEOUT)) begin
                     d.state    = IDLE;
                     d.snz_cnt  = 4'd0;
                     d.ring_min = 6'd0;
                  end else begin
                     d.ring_min = q.ring_min + 6'd1;
                  end
               end
            end
            SNOOZING: begin
               if (one_minute && (current_time == q.wake_time)) begin
                  d.state    = RINGING;
                  d.ring_min = 6'd0;
               end
            end
            default: d.state = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Display mux
   // ---------------------------------------------------------------------
   // If show_sel points past the last slot, no slot compare matches and
   // the display shows blank zeros.
   always_comb begin
      disp_nxt = current_time;
      if (show_alarm) begin
         disp_nxt = 16'h0000;
         for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if (show_sel == 3'(i)) disp_nxt = slots[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         q           <= '0;
         sound_alarm <= 1'b0;
         display     <= 16'h0000;
      end else begin
         q           <= d;
         sound_alarm <= (d.state == RINGING);
         display     <= disp_nxt;
      end
   end

   assign active_alarm = q.active;
   assign snooze_count = q.snz_cnt;

endmodule
